// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and constants for the parameterised UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int RX_MIN_PERIOD  = 4;
    localparam int RX_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        DONE   = 3'd5
    } rx_param_state_t;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// uart_rx_bit_timer: per-bit period counter with mid-bit and end-of-bit strobes.
module uart_rx_bit_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] period,
    output logic             half,
    output logic             fin
);

    logic [DIV_W-1:0] count;

    assign half = count == (period >> 1);
    assign fin  = count == period - DIV_W'(1);

    // Restarting at the end of each bit keeps the counter from ever wrapping.
    always_ff @(posedge clk or posedge rst)
        if (rst)
            count <= '0;
        else
            count <= (clr || fin) ? '0 : count + DIV_W'(1);

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: UART receiver with runtime bit period, sticky error flags and ack handshake.
// Optional parity checking is compiled in with UART_RX_PARITY_EN.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    input  logic [DIV_W-1:0]  bit_period_i,
    input  logic              parity_odd_i,
    input  logic              ack_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              frame_err_o,
    output logic              parity_err_o,
    output logic              overrun_o,
    output logic              busy_o
);

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_width
        $error("uart_rx_param: DATA_W must be 5..9");
    end

    rx_param_state_t state, next;

    logic [RX_SYNC_STAGES-1:0] sync_q;
    logic rxs, rxs_d;
    logic [DIV_W-1:0] period_q;
    logic half, fin, clr, last;
    logic [DATA_W-1:0] sh;
    logic [3:0] bit_cnt;
    logic ferr_q;

    assign rxs  = sync_q[RX_SYNC_STAGES-1];
    assign last = bit_cnt == 4'(DATA_W - 1);
    assign clr  = state == IDLE || state != next;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sync_q <= '1;
            rxs_d  <= 1'b1;
        end else begin
            sync_q <= {sync_q[RX_SYNC_STAGES-2:0], rx_i};
            rxs_d  <= rxs;
        end

    uart_rx_bit_timer #(.DIV_W(DIV_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .period (period_q),
        .half   (half),
        .fin    (fin)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst)
            state <= IDLE;
        else
            state <= next;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = (!rxs && rxs_d) ? START : IDLE;
            START:   next = half ? (rxs ? IDLE : DATA) : START;
`ifdef UART_RX_PARITY_EN
            DATA:    next = (fin && last) ? PARITY : DATA;
            PARITY:  next = fin ? STOP : PARITY;
`else
            DATA:    next = (fin && last) ? STOP : DATA;
`endif
            STOP:    next = fin ? DONE : STOP;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb busy_o = state != IDLE;

    // Acknowledge is applied before the DONE update so a same-cycle ack never overruns.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            period_q    <= '0;
            sh          <= '0;
            bit_cnt     <= '0;
            ferr_q      <= 1'b0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (state == IDLE && next == START)
                period_q <= bit_period_i;
            if (state == START) begin
                bit_cnt <= '0;
                ferr_q  <= 1'b0;
            end
            if (state == DATA && fin) begin
                sh      <= {rxs, sh[DATA_W-1:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (state == STOP && fin)
                ferr_q <= !rxs;
            if (ack_i) begin
                valid_o     <= 1'b0;
                frame_err_o <= 1'b0;
                overrun_o   <= 1'b0;
            end
            if (state == DONE) begin
                if (valid_o && !ack_i)
                    overrun_o <= 1'b1;
                else begin
                    data_o      <= sh;
                    valid_o     <= 1'b1;
                    frame_err_o <= ferr_q;
                end
            end
        end

`ifdef UART_RX_PARITY_EN
    logic perr_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            perr_q       <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            if (state == START)
                perr_q <= 1'b0;
            if (state == PARITY && fin)
                perr_q <= rxs != (^sh ^ parity_odd_i);
            if (ack_i)
                parity_err_o <= 1'b0;
            if (state == DONE && !(valid_o && !ack_i))
                parity_err_o <= perr_q;
        end
`else
    logic unused_parity;

    assign unused_parity = parity_odd_i;
    assign parity_err_o  = 1'b0;
`endif

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter DATA_W, 8, data bits per frame; the legal range SHALL be 5..9.
REQ-002 Parameter DIV_W, 16, width of bit_period_i.
REQ-003 Port clk  input  1  clock; all sequential logic SHALL be on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port rx_i  input  1  serial line, asynchronous to clk, idle high.
REQ-006 Port bit_period_i  input  DIV_W  clocks per bit; it SHALL be sampled only in IDLE, and the legal minimum SHALL be 4.
REQ-007 Port parity_odd_i  input  1  1 = odd parity, 0 = even; it SHALL be ignored when parity is compiled out.
REQ-008 Port ack_i  input  1  consumer acknowledge; it SHALL clear valid_o and all error flags.
REQ-009 Port data_o  output  DATA_W  received word, LSB-first on the line.
REQ-010 Port valid_o  output  1  level-high while data_o holds an unacknowledged word.
REQ-011 Port frame_err_o / parity_err_o / overrun_o  output  1 each  sticky error flags.
REQ-012 Port busy_o  output  1  high in every state except IDLE.

Function
REQ-013 rx_i SHALL pass through a 2-flop synchroniser whose flops reset to 1; the logic SHALL use the synchronised value rxs plus a one-cycle delayed copy rxs_d.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, DONE.
REQ-015 IDLE->START SHALL occur only on a falling edge, rxs==0 && rxs_d==1; a held-low line (break) SHALL NOT retrigger.
REQ-016 On entry to START, DATA, PARITY and STOP, the period counter SHALL clear; bit_period_i SHALL be latched into period_q when leaving IDLE.
REQ-017 START: at count == period_q>>1, rxs==0 SHALL go to DATA; otherwise (false start) SHALL go to IDLE with no flags.
REQ-018 DATA: rxs SHALL be sampled at count == period_q-1 and shifted into bit DATA_W-1 of a right-shift register.
REQ-019 After DATA_W samples, DATA SHALL go to PARITY if compiled in, else to STOP.
REQ-020 STOP: rxs SHALL be sampled at count == period_q-1; rxs==0 SHALL mark a frame error; the FSM SHALL then go to DONE.
REQ-021 DONE SHALL last one cycle and then go to IDLE.
REQ-022 DONE with valid_o==0: data_o SHALL load, valid_o SHALL set, and the frame/parity errors of this frame SHALL set their flags.
REQ-023 DONE with valid_o==1 and no ack_i: the new word SHALL be dropped, data_o SHALL be unchanged, and overrun_o SHALL set.
REQ-024 ack_i in the same cycle as DONE: the acknowledge SHALL apply first and the new word SHALL load without overrun.
REQ-025 Latency: valid_o SHALL rise 2 (sync) + 1 + (period_q>>1) + (DATA_W[+1]+1)*period_q + 2 clocks after the rx_i falling edge, ±1 clock.
REQ-026 ack_i while valid_o==0 SHALL have no effect.
REQ-027 The period counter SHALL be DIV_W bits wide; comparisons SHALL be unsigned and the counter SHALL never wrap within a bit.

Reset
REQ-028 Reset SHALL force state to IDLE, counter and shift register to 0, data_o to 0, and valid_o, frame_err_o, parity_err_o, overrun_o and busy_o to 0.
REQ-029 Reset mid-frame SHALL abort the frame with no output or flag change after release.
REQ-030 After reset release, the receiver SHALL wait for a fresh falling edge.

Configuration
REQ-031 With macro UART_RX_PARITY_EN defined, the PARITY state SHALL sample one bit at count == period_q-1 and compare it with XOR(data)^parity_odd_i; a mismatch SHALL flag a parity error.
REQ-032 Without UART_RX_PARITY_EN, the PARITY state and its logic SHALL be absent, parity_err_o SHALL be tied 0, and the frame SHALL be 1+DATA_W+1 bits.

Structure
REQ-033 The state enum rx_param_state_t and constants RX_MIN_PERIOD=4 and RX_SYNC_STAGES=2 SHALL live in uart_pkg.
REQ-034 The period counter and its half-period and end-period compare strobes SHALL be a sub-module, uart_rx_bit_timer.

Verification
REQ-035 Scenario: DATA_W=8, period 16, parity off, send 0xA5 with stop=1 -> data_o=0xA5, valid_o=1, all flags 0.
REQ-036 Scenario: rx_i low for 5 clocks then high, period 16 -> return to IDLE, valid_o stays 0, busy_o deasserts.
REQ-037 Scenario: send 0x3C with stop=0 -> data_o=0x3C, frame_err_o=1; line held low afterwards produces no second frame.
REQ-038 Scenario: send 0x11 then 0x22 without ack_i -> data_o=0x11, overrun_o=1; ack_i clears valid_o and overrun_o.
REQ-039 Scenario: UART_RX_PARITY_EN, even parity, send 0x07 with parity bit 0 -> parity_err_o=1; with parity bit 1 -> parity_err_o=0.
REQ-040 Scenario: assert rst mid-DATA, then send 0x5A -> only 0x5A is reported, with no flags.
